// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared types and helpers for the pipelined ripple-carry adder.
//               Holds the default operand/stage geometry, the stage-register
//               record for that default geometry and the per-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    localparam int DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

    // Stage-register record for the default geometry. Only the upper,
    // not-yet-added chunks of A and b_eff need to travel; the low chunks are
    // already folded into sum_lo.
    typedef struct packed {
        logic [DEF_WIDTH-DEF_CHUNK-1:0] sum_lo;
        logic [DEF_WIDTH-DEF_CHUNK-1:0] a_hi;
        logic [DEF_WIDTH-DEF_CHUNK-1:0] b_hi;
        logic                           carry;
        logic                           msb_cin;
        logic                           valid;
    } rca_stage_t;

    // Returns {carry, sum} for one full-adder bit.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage : rca_pkg
`default_nettype wire

// File: rtl/pipelined_rca_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : rca_chunk
// Description : Combinational CHUNK-bit ripple-carry adder; the generalised
//               form of the original 3-bit adder. One instance per stage.
// Ports       : a_i, b_i   - CHUNK-bit operands
//               cin_i      - carry into bit 0
//               sum_o      - CHUNK-bit sum
//               cout_o     - carry out of the top bit
//               msb_cin_o  - carry into the top bit (used for overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module rca_chunk
    import rca_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    always_comb begin : ripple
        logic       c;
        logic [1:0] fa;
        c         = cin_i;
        fa        = 2'b00;
        sum_o     = '0;
        msb_cin_o = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_cin_o = c;
            end
            fa       = full_add(a_i[i], b_i[i], c);
            sum_o[i] = fa[0];
            c        = fa[1];
        end
        cout_o = c;
    end

endmodule : rca_chunk
`default_nettype wire

// File: rtl/pipelined_rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca_adder
// Description : WIDTH-bit add/subtract split into STAGES register-separated
//               ripple chunks, with a valid/ready stream on both sides and
//               per-stage bubble collapse (one op per cycle throughput).
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - operand handshake
//               in_a, in_b           - operands
//               in_cin               - carry-in (ADD only)
//               in_sub               - 1: A - B, 0: A + B + cin
//               out_valid / out_ready- result handshake
//               out_sum, out_cout    - result and MSB carry (SUB: 1 = no borrow)
//               out_ovf              - signed two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rca_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $fatal(1, "pipelined_rca_adder: illegal WIDTH/STAGES combination");
        end
    endgenerate

    // Full-width fields keep the per-stage slicing uniform; the already-added
    // low bits of a_hi/b_hi and the not-yet-added high bits of sum_lo are dead
    // and trimmed by synthesis.
    typedef struct packed {
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             carry;
        logic             msb_cin;
        logic             valid;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            src     [STAGES];   // what feeds stage k this cycle
    logic [STAGES-1:0] adv;                // stage k loads stage_d[k] on this edge

    logic [CHUNK-1:0]  chunk_a    [STAGES];
    logic [CHUNK-1:0]  chunk_b    [STAGES];
    logic [CHUNK-1:0]  chunk_sum  [STAGES];
    logic              chunk_cout [STAGES];
    logic              chunk_msb  [STAGES];

    // Ready chain: a stage may load when it is empty or its successor moves.
    // This makes in_ready combinational from out_ready.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready || !stage_q[STAGES-1].valid;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !stage_q[k].valid || adv[k+1];
        end
    end

    // Stage 0 is fed by the conditioned operands; SUB forms A + ~B + 1.
    always_comb begin
        src[0].sum_lo  = '0;
        src[0].a_hi    = in_a;
        src[0].b_hi    = in_sub ? ~in_b : in_b;
        src[0].carry   = in_sub ? 1'b1 : in_cin;
        src[0].msb_cin = 1'b0;
        src[0].valid   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            assign chunk_a[k] = src[k].a_hi[k*CHUNK +: CHUNK];
            assign chunk_b[k] = src[k].b_hi[k*CHUNK +: CHUNK];

            rca_chunk #(
                .CHUNK (CHUNK)
            ) u_chunk (
                .a_i       (chunk_a[k]),
                .b_i       (chunk_b[k]),
                .cin_i     (src[k].carry),
                .sum_o     (chunk_sum[k]),
                .cout_o    (chunk_cout[k]),
                .msb_cin_o (chunk_msb[k])
            );
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (src[k].valid) begin
                stage_d[k]                           = src[k];
                stage_d[k].sum_lo[k*CHUNK +: CHUNK]  = chunk_sum[k];
                stage_d[k].carry                     = chunk_cout[k];
                stage_d[k].msb_cin                   = chunk_msb[k];
            end else begin
                // Bubble: keep the old payload, only the valid bit drops.
                stage_d[k]       = stage_q[k];
                stage_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = stage_q[STAGES-1].valid;
    assign out_sum   = stage_q[STAGES-1].sum_lo;
    assign out_cout  = stage_q[STAGES-1].carry;
    assign out_ovf   = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].msb_cin;

endmodule : pipelined_rca_adder
`default_nettype wire
